nios2_sysid_checker: RTL
========================

NIOS2_SYSID_CHECKER -- requirements
Module: nios2_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0: system ID value expected at sysid word 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1570018685: timestamp value expected at sysid word 1.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 1..15: number of clock edges between an address change and the first sample.
REQ-004 SHALL have parameter MAX_RETRY, default 3, legal range 0..7: number of allowed re-samples per word after inconsistent samples.
REQ-005 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1: request a check; sampled only in IDLE.
REQ-008 SHALL have port sid_address, output, 1: registered word select driven to the sysid slave.
REQ-009 SHALL have port sid_readdata, input, 32: sysid slave read data, combinational from sid_address.
REQ-010 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port pass, output, 1: id_ok AND ts_ok AND NOT unstable.
REQ-013 SHALL have ports id_ok and ts_ok, output, 1 each: per-word compare result.
REQ-014 SHALL have port unstable, output, 1: retry budget exhausted on either word.
REQ-015 SHALL have ports captured_id and captured_ts, output, 32 each: last accepted sample of each word.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ID, RD_TS and FINISH.
REQ-017 SHALL, on the start edge in IDLE, enter RD_ID, set sid_address=0, clear wait/retry counters and clear id_ok, ts_ok, unstable and pass.
REQ-018 SHALL, in RD_ID and RD_TS, capture sample A on the WAIT_CYCLES-th edge after entering the state and sample B on the next edge.
REQ-019 SHALL compare A and B at the sample-B edge; A==B accepts the word.
REQ-020 SHALL, when A!=B and retry<MAX_RETRY, increment retry and capture a new A/B pair on the next two edges with no extra wait.
REQ-021 SHALL, when A!=B and retry==MAX_RETRY, set unstable, accept sample B and continue.
REQ-022 SHALL, on acceptance in RD_ID, load captured_id, set id_ok=(value==EXPECTED_ID), set sid_address=1, reset wait/retry counters and enter RD_TS.
REQ-023 SHALL, on acceptance in RD_TS, load captured_ts, set ts_ok=(value==EXPECTED_TS) and enter FINISH.
REQ-024 SHALL, in FINISH, assert done for exactly one cycle with pass valid in that same cycle, set sid_address=0 and return to IDLE on the next edge.
REQ-025 SHALL have a no-retry latency of 2*(WAIT_CYCLES+1) edges from the start edge to the FINISH entry edge (4 edges for the default WAIT_CYCLES); each retry SHALL add 2 edges.
REQ-026 SHALL ignore start whenever busy=1, with no queuing.
REQ-027 SHALL hold id_ok, ts_ok, unstable, pass, captured_id and captured_ts stable from FINISH until the next accepted start.
REQ-028 SHALL use retry counters of 3 bits and wait counters of 4 bits, with no wrap-around reachable within the legal parameter ranges.

Reset
REQ-029 SHALL, while reset_n=0 at a clock edge, force state=IDLE, sid_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, unstable=0, captured_id=0, captured_ts=0 and all counters to 0.
REQ-030 SHALL, on reset asserted mid-check, abandon the check with no done pulse; reset SHALL take priority over start on the same edge.

Verification
REQ-031 SHALL verify: slave model returns 0 at address 0 and 1570018685 at address 1, with default parameters and a start pulse -> done high 4 edges after the start edge, pass=1, captured_ts=1570018685.
REQ-032 SHALL verify: slave returns 32'h0000_0001 at address 0 -> done asserted, id_ok=0, ts_ok=1, pass=0, captured_id=1.
REQ-033 SHALL verify: word-1 samples differ once and then are stable -> one retry, done at edge 6, pass=1, unstable=0.
REQ-034 SHALL verify: word-0 samples alternate every cycle with MAX_RETRY=3 -> unstable=1, pass=0, done at edge 10.
REQ-035 SHALL verify: start re-pulsed while busy, and reset_n=0 at edge 2 of a check -> extra start ignored; after reset all outputs are 0 and no done pulse occurs.
REQ-036 SHALL verify: WAIT_CYCLES=3 with a good slave -> done at edge 8, and sid_address=1 from edge 4 until FINISH.

Source files
------------

// File: rtl/nios2_sysid_checker_if.sv
// Bus between the sysid checker and the Nios II sysid slave.
//   sid_address  : word select (0 = system ID, 1 = timestamp), driven by the checker
//   sid_readdata : read data, combinational from sid_address, driven by the slave
interface nios2_sysid_checker_if;
  logic        sid_address;
  logic [31:0] sid_readdata;

  modport master (output sid_address, input sid_readdata);
  modport slave  (input sid_address, output sid_readdata);
endinterface

// File: rtl/nios2_sysid_checker.sv
// Reads both words of a Nios II sysid slave and compares them against the
// expected system ID and timestamp. Each word is sampled twice on consecutive
// edges; a mismatch between the two samples triggers a bounded re-sample.
//
// Ports:
//   clock        : single rising-edge clock
//   reset_n      : synchronous active-low reset
//   start        : request a check (honoured only while idle)
//   sid          : sysid bus (master side)
//   busy         : high in every state other than IDLE
//   done         : one-cycle completion pulse, results valid alongside it
//   pass         : id_ok & ts_ok & ~unstable
//   id_ok, ts_ok : per-word compare results
//   unstable     : retry budget exhausted on either word
//   captured_id  : last accepted system ID sample
//   captured_ts  : last accepted timestamp sample
module nios2_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1570018685,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  nios2_sysid_checker_if.master    sid,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     id_ok,
  output logic                     ts_ok,
  output logic                     unstable,
  output logic [31:0]              captured_id,
  output logic [31:0]              captured_ts
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t      state_q, state_d;
  logic        addr_q, addr_d;
  logic [3:0]  wait_q, wait_d;
  logic [2:0]  retry_q, retry_d;
  logic        phase_b_q, phase_b_d;   // next edge in the read state takes sample B
  logic [31:0] sample_a_q, sample_a_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        unstable_q, unstable_d;
  logic [31:0] cap_id_q, cap_id_d;
  logic [31:0] cap_ts_q, cap_ts_d;
  logic        accept;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 1'b0;
      wait_q     <= '0;
      retry_q    <= '0;
      phase_b_q  <= 1'b0;
      sample_a_q <= '0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      unstable_q <= 1'b0;
      cap_id_q   <= '0;
      cap_ts_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      retry_q    <= retry_d;
      phase_b_q  <= phase_b_d;
      sample_a_q <= sample_a_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      unstable_q <= unstable_d;
      cap_id_q   <= cap_id_d;
      cap_ts_q   <= cap_ts_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    retry_d    = retry_q;
    phase_b_d  = phase_b_q;
    sample_a_d = sample_a_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    unstable_d = unstable_q;
    cap_id_d   = cap_id_q;
    cap_ts_d   = cap_ts_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD_ID;
          addr_d     = 1'b0;
          wait_d     = '0;
          retry_d    = '0;
          phase_b_d  = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          unstable_d = 1'b0;
        end
      end

      RD_ID, RD_TS: begin
        if (!phase_b_q) begin
          if (wait_q == WAIT_LAST) begin
            sample_a_d = sid.sid_readdata;
            phase_b_d  = 1'b1;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end else if (sample_a_q == sid.sid_readdata) begin
          accept = 1'b1;
        end else if (retry_q < RETRY_MAX) begin
          // Preloading the wait counter makes the re-sample take A on the very next edge.
          retry_d   = retry_q + 3'd1;
          phase_b_d = 1'b0;
          wait_d    = WAIT_LAST;
        end else begin
          unstable_d = 1'b1;
          accept     = 1'b1;
        end

        if (accept) begin
          phase_b_d = 1'b0;
          wait_d    = '0;
          retry_d   = '0;
          if (state_q == RD_ID) begin
            cap_id_d = sid.sid_readdata;
            id_ok_d  = (sid.sid_readdata == EXPECTED_ID);
            addr_d   = 1'b1;
            state_d  = RD_TS;
          end else begin
            cap_ts_d = sid.sid_readdata;
            ts_ok_d  = (sid.sid_readdata == EXPECTED_TS);
            state_d  = FINISH;
          end
        end
      end

      FINISH: begin
        addr_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign sid.sid_address = addr_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FINISH);
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign unstable        = unstable_q;
  assign pass            = id_ok_q & ts_ok_q & ~unstable_q;
  assign captured_id     = cap_id_q;
  assign captured_ts     = cap_ts_q;

endmodule
